adder_share_arbiter: RTL and testbench
======================================

Name: adder_share_arbiter

Overview:
- Shares one two-stage pipelined 8-bit adder core among NUM_REQ requesters.
- Each cycle, the arbiter grants at most one valid request, issues its operands into the pipeline, and carries the requester ID alongside the data.
- Returns each result two cycles later with the requester ID attached.
- Sits between client blocks needing occasional 8-bit adds and the single shared adder datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of requester ID.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_fixed_prio  input  1  1 = fixed priority (index 0 highest); 0 = round robin.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*8  operand A; requester i occupies bits [8i+7:8i].
- req_b  input  NUM_REQ*8  operand B, same packing as req_a.
- req_cin  input  NUM_REQ  per-requester carry-in.
- req_ready  output  NUM_REQ  one-hot grant; a request is accepted when req_valid[i] & req_ready[i] at a clk edge.
- resp_valid  output  1  result valid, single-cycle per result.
- resp_id  output  ID_W  requester index of the result.
- resp_sum  output  8  A+B+cin, bits [7:0].
- resp_cout  output  1  carry out of bit 7.

Behaviour:
- Reset values:
  - resp_valid=0, resp_id=0, resp_sum=0, resp_cout=0.
  - Round-robin pointer=0; both pipeline valid bits=0.
  - req_ready=0 in every cycle where rst=1.
- Grant (combinational from req_valid, pointer and cfg_fixed_prio):
  - Round robin: search indices ptr, ptr+1, … wrapping modulo NUM_REQ; the first valid index wins.
  - Fixed priority: the lowest valid index wins; pointer is unchanged.
  - req_ready is all-zero when no request is valid.
  - req_ready[i] may depend on req_valid; requesters must hold operands stable while valid and not ready.
- Pointer update (round robin only): on an accepted grant to index w, ptr <= (w+1) mod NUM_REQ. No grant leaves ptr unchanged.
- Issue rate: one accept per cycle maximum. No backpressure on responses; the pipeline never stalls.
- Stage 1 (edge E0 = accept edge) registers:
  - sum of A[3:0]+B[3:0]+cin;
  - low-nibble carry;
  - A[7:4] and B[7:4];
  - winner ID;
  - s1_valid=1.
- Stage 2 (edge E1): registers high-nibble sum (A[7:4]+B[7:4]+low carry), the low sum, cout, ID, and s2_valid=s1_valid.
- Response outputs are driven from stage 2. resp_valid is high in the cycle following E1, i.e. latency 2 edges from accept.
- Arithmetic is modulo 256 with carry out; {resp_cout,resp_sum} equals the 9-bit value A+B+cin.
- Back-to-back accepts produce back-to-back responses in accept order. No reordering and no drops.
- resp_id/resp_sum/resp_cout hold their last values while resp_valid=0.
- Changing cfg_fixed_prio takes effect on the next grant decision. In-flight operations are unaffected.
- Reset mid-operation:
  - In-flight operations are discarded; no response is generated for them.
  - resp_valid is 0 in the cycle after rst is sampled high.
  - The pointer returns to 0.
- A requester deasserting valid before being granted is legal; nothing is issued for it.

Decomposition:
- Package adder_share_pkg: DATA_W=8 constant, NIBBLE_W=4 constant, and a stage-1 struct typedef (lo_sum, lo_carry, a_hi, b_hi, id, valid).
- One sub-module: rr_grant_picker. Inputs: req vector, ptr, fixed-priority flag. Outputs: one-hot grant, winner index, any_grant.
- The adder stages stay inline in adder_share_arbiter.

Test Plan:
1. Single request: req0 A=8'h3C, B=8'h0F, cin=0 → req_ready=4'b0001; two edges later resp_valid=1, resp_id=0, resp_sum=8'h4B, resp_cout=0.
2. Carry across nibbles and overflow: req2 A=8'hFF, B=8'h01, cin=1 → resp_id=2, resp_sum=8'h01, resp_cout=1.
3. Round robin with all four requesters continuously valid, ptr=0:
   - grants 0,1,2,3,0 on consecutive cycles;
   - responses arrive in the same ID order on consecutive cycles.
4. Fixed priority, req1 and req3 valid for 3 cycles → req1 granted all 3 cycles, req3 never granted. After switching to round robin, req3 is granted within 2 cycles.
5. Reset mid-flight: accept req0 at E0; assert rst before E1 → no resp_valid follows; ptr=0 and req_ready=0 during rst.
6. Random operands, 1000 accepts, random valid patterns → every response matches the 9-bit reference sum and the accept-order ID, with no lost or duplicate responses.

Source files
------------

// File: rtl/adder_share_pkg.sv
// Shared constants and the stage-1 pipeline record for the shared adder arbiter.
package adder_share_pkg;

    localparam int DATA_W   = 8;
    localparam int NIBBLE_W = 4;
    // Wide enough for the largest supported requester count (8).
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [NIBBLE_W-1:0] lo_sum;
        logic                lo_carry;
        logic [NIBBLE_W-1:0] a_hi;
        logic [NIBBLE_W-1:0] b_hi;
        logic [MAX_ID_W-1:0] id;
        logic                valid;
    } s1_t;

endpackage

// File: rtl/rr_grant_picker.sv
// Picks one requester: lowest index in fixed mode, first valid at or after ptr otherwise.
module rr_grant_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               fixed_prio,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any_grant
);

    int idx;

    always_comb begin
        grant     = '0;
        winner    = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = fixed_prio ? k : int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                winner     = idx[ID_W-1:0];
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Arbitrates NUM_REQ requesters onto one two-stage nibble-split 8-bit adder;
// results come back two edges after accept, tagged with the requester ID.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_fixed_prio,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_sum,
    output logic                      resp_cout
);

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    winner;
    logic               any_grant;
    logic               accept;

    logic [ID_W-1:0]    ptr_q, ptr_d;
    s1_t                s1_q, s1_d;
    logic               s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]  s2_sum_q, s2_sum_d;
    logic               s2_cout_q, s2_cout_d;
    logic [ID_W-1:0]    s2_id_q, s2_id_d;

    logic [DATA_W-1:0]  win_a, win_b;
    logic               win_cin;
    logic [NIBBLE_W:0]  lo_full, hi_full;
    logic               unused_id_bits;

    rr_grant_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req        (req_valid),
        .ptr        (ptr_q),
        .fixed_prio (cfg_fixed_prio),
        .grant      (grant),
        .winner     (winner),
        .any_grant  (any_grant)
    );

    // No grants are offered while reset is held, so nothing can be accepted then.
    assign req_ready = rst ? '0 : grant;
    assign accept    = any_grant & ~rst;

    assign win_a   = req_a[winner*DATA_W +: DATA_W];
    assign win_b   = req_b[winner*DATA_W +: DATA_W];
    assign win_cin = req_cin[winner];

    always_comb begin
        ptr_d = ptr_q;
        if (accept && !cfg_fixed_prio) begin
            ptr_d = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

    always_comb begin
        lo_full = {1'b0, win_a[NIBBLE_W-1:0]} + {1'b0, win_b[NIBBLE_W-1:0]}
                + {{NIBBLE_W{1'b0}}, win_cin};
        s1_d                = '0;
        s1_d.lo_sum         = lo_full[NIBBLE_W-1:0];
        s1_d.lo_carry       = lo_full[NIBBLE_W];
        s1_d.a_hi           = win_a[DATA_W-1:NIBBLE_W];
        s1_d.b_hi           = win_b[DATA_W-1:NIBBLE_W];
        s1_d.id[ID_W-1:0]   = winner;
        s1_d.valid          = accept;
    end

    // Stage-2 data only loads on a valid stage-1 entry so responses hold when idle.
    always_comb begin
        hi_full    = {1'b0, s1_q.a_hi} + {1'b0, s1_q.b_hi}
                   + {{NIBBLE_W{1'b0}}, s1_q.lo_carry};
        s2_valid_d = s1_q.valid;
        s2_sum_d   = s2_sum_q;
        s2_cout_d  = s2_cout_q;
        s2_id_d    = s2_id_q;
        if (s1_q.valid) begin
            s2_sum_d  = {hi_full[NIBBLE_W-1:0], s1_q.lo_sum};
            s2_cout_d = hi_full[NIBBLE_W];
            s2_id_d   = s1_q.id[ID_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_cout_q  <= 1'b0;
            s2_id_q    <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_q       <= s1_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_cout_q  <= s2_cout_d;
            s2_id_q    <= s2_id_d;
        end
    end

    assign unused_id_bits = ^s1_q.id;

    assign resp_valid = s2_valid_q;
    assign resp_id    = s2_id_q;
    assign resp_sum   = s2_sum_q;
    assign resp_cout  = s2_cout_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_adder_share_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           cfg_fixed_prio;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_a;
    logic [N*8-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_ready;
    logic           resp_valid;
    logic [1:0]     resp_id;
    logic [7:0]     resp_sum;
    logic           resp_cout;

    adder_share_arbiter #(.NUM_REQ(N)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_fixed_prio (cfg_fixed_prio),
        .req_valid      (req_valid),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_cin        (req_cin),
        .req_ready      (req_ready),
        .resp_valid     (resp_valid),
        .resp_id        (resp_id),
        .resp_sum       (resp_sum),
        .resp_cout      (resp_cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int total;
        int due;
    } exp_t;

    exp_t         exp_q[$];
    int           checks     = 0;
    int           errors     = 0;
    int           ptr_m      = 0;
    int           edges      = 0;
    int           last_id    = 0;
    int           last_total = 0;
    int           acc_idx    = -1;
    int           acc_count  = 0;
    logic [N-1:0] seen_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    function automatic int model_winner();
        int i;
        for (int j = 0; j < N; j++) begin
            i = cfg_fixed_prio ? j : (ptr_m + j) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check grant and response mid-cycle, then advance the model across the edge.
    task automatic run_cycle();
        int   w;
        bit   due;
        exp_t e;
        @(negedge clk);
        w = rst ? -1 : model_winner();
        seen_ready = req_ready;
        check("req_ready", 32'(req_ready), (w < 0) ? 32'd0 : 32'(1 << w));
        while (exp_q.size() > 0 && exp_q[0].due < edges) void'(exp_q.pop_front());
        due = exp_q.size() > 0 && exp_q[0].due == edges;
        check("resp_valid", 32'(resp_valid), 32'(due));
        if (due) begin
            e          = exp_q.pop_front();
            last_id    = e.id;
            last_total = e.total;
        end
        check("resp_id", 32'(resp_id), 32'(last_id));
        check("resp_sum", 32'({resp_cout, resp_sum}), 32'(last_total));
        acc_idx = w;
        if (w >= 0) begin
            e.id    = w;
            e.total = int'(req_a[w*8 +: 8]) + int'(req_b[w*8 +: 8]) + int'(req_cin[w]);
        end
        @(posedge clk);
        edges++;
        if (rst) begin
            exp_q.delete();
            ptr_m      = 0;
            last_id    = 0;
            last_total = 0;
            acc_idx    = -1;
        end else if (w >= 0) begin
            e.due = edges + 1;
            exp_q.push_back(e);
            acc_count++;
            if (!cfg_fixed_prio) ptr_m = (w + 1) % N;
        end
        #1;
    endtask

    initial begin
        int  base;
        int  budget;
        bit  seen3;

        rst            = 1'b1;
        cfg_fixed_prio = 1'b0;
        req_valid      = '0;
        req_a          = '0;
        req_b          = '0;
        req_cin        = '0;
        run_cycle();
        run_cycle();
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        run_cycle();

        // Single request, no carry across the top.
        req_valid    = 4'b0001;
        req_a[7:0]   = 8'h3C;
        req_b[7:0]   = 8'h0F;
        req_cin[0]   = 1'b0;
        run_cycle();
        check("t1_ready", 32'(seen_ready), 32'h1);
        req_valid = '0;
        run_cycle();
        check("t1_valid", 32'(resp_valid), 32'd1);
        check("t1_id", 32'(resp_id), 32'd0);
        check("t1_sum", 32'({resp_cout, resp_sum}), 32'h04B);

        // Carry ripples through both nibbles and out.
        req_valid    = 4'b0100;
        req_a[23:16] = 8'hFF;
        req_b[23:16] = 8'h01;
        req_cin[2]   = 1'b1;
        run_cycle();
        check("t2_ready", 32'(seen_ready), 32'h4);
        req_valid = '0;
        run_cycle();
        check("t2_valid", 32'(resp_valid), 32'd1);
        check("t2_id", 32'(resp_id), 32'd2);
        check("t2_sum", 32'({resp_cout, resp_sum}), 32'h101);

        // Reset between accept and stage 2.
        req_valid  = 4'b0001;
        req_a[7:0] = 8'h11;
        req_b[7:0] = 8'h22;
        run_cycle();
        rst = 1'b1;
        run_cycle();
        check("t5_no_resp", 32'(resp_valid), 32'd0);
        run_cycle();
        check("t5_ready_in_rst", 32'(seen_ready), 32'd0);
        rst       = 1'b0;
        req_valid = '0;
        run_cycle();
        check("t5_no_resp_after", 32'(resp_valid), 32'd0);

        // Round robin with everyone requesting, pointer freshly reset.
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) begin
            req_a[i*8 +: 8] = 8'($urandom);
            req_b[i*8 +: 8] = 8'($urandom);
            req_cin[i]      = 1'($urandom);
        end
        for (int k = 0; k < 5; k++) begin
            run_cycle();
            check("t3_grant", 32'(seen_ready), 32'(1 << (k % N)));
            if (k >= 1) begin
                check("t3_resp_valid", 32'(resp_valid), 32'd1);
                check("t3_resp_id", 32'(resp_id), 32'((k - 1) % N));
            end
        end
        req_valid = '0;
        run_cycle();
        check("t3_resp_id_last", 32'(resp_id), 32'd0);
        run_cycle();

        // Fixed priority starves req3, round robin reaches it quickly.
        cfg_fixed_prio = 1'b1;
        req_valid      = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            run_cycle();
            check("t4_fixed_grant", 32'(seen_ready), 32'h2);
        end
        cfg_fixed_prio = 1'b0;
        seen3          = 1'b0;
        for (int k = 0; k < 2; k++) begin
            run_cycle();
            if (seen_ready[3]) seen3 = 1'b1;
        end
        check("t4_rr_req3", 32'(seen3), 32'd1);

        // Random traffic; requesters hold operands until granted and may withdraw.
        base   = acc_count;
        budget = 0;
        while (acc_count - base < 1000 && budget < 20000) begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && acc_idx != i) begin
                    if ($urandom_range(15) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i]    = 1'($urandom_range(1));
                    req_a[i*8 +: 8] = 8'($urandom);
                    req_b[i*8 +: 8] = 8'($urandom);
                    req_cin[i]      = 1'($urandom);
                end
            end
            if ($urandom_range(31) == 0) cfg_fixed_prio = ~cfg_fixed_prio;
            run_cycle();
            budget++;
        end
        check("rand_accepts", 32'(acc_count - base >= 1000), 32'd1);

        req_valid = '0;
        for (int k = 0; k < 4; k++) run_cycle();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
